// File: rtl/rope_anim_ctrl.sv
// Tug-of-war rope animation controller: turns round results into sprite start columns.
// Optional winner flash is built only when WIN_FLASH_EN is defined.
module rope_anim_ctrl #(
  parameter int RED_HOME   = 500,
  parameter int BLUE_HOME  = 300,
  parameter int STEP       = 16,
  parameter int MAX_OFFSET = 96,
  parameter int ANIM_RATE  = 2
`ifdef WIN_FLASH_EN
  ,
  parameter int FLASH_FRAMES = 15
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_start_i,
  input  logic       round_pulse_i,
  input  logic       right_i,
  input  logic       tie_i,
  input  logic       game_clear_i,
  output logic [9:0] red_start_o,
  output logic [9:0] blue_start_o,
  output logic [1:0] winner_o,
  output logic       anim_busy_o,
  output logic       flash_o
);

  typedef enum logic {PLAY, OVER} state_e;

  localparam logic signed [9:0]  StepS = 10'(STEP);
  localparam logic signed [9:0]  MaxS  = 10'(MAX_OFFSET);
  localparam logic signed [9:0]  RateS = 10'(ANIM_RATE);
  localparam logic signed [10:0] RateW = 11'(ANIM_RATE);
  localparam logic [9:0]         RedHome  = 10'(RED_HOME);
  localparam logic [9:0]         BlueHome = 10'(BLUE_HOME);

  state_e            state_q, state_d;
  logic signed [9:0] target_q, target_d;
  logic signed [9:0] cur_q, cur_d;
  logic [9:0]        red_q, red_d;
  logic [9:0]        blue_q, blue_d;
  logic [1:0]        winner_q, winner_d;
  logic              busy_q, busy_d;
  logic signed [10:0] diff;
  logic              reached;

  // The frame step always uses the target held before this edge, so a round
  // arriving with frame_start only shows up on the following frame.
  always_comb begin
    diff  = {target_q[9], target_q} - {cur_q[9], cur_q};
    cur_d = cur_q;
    if (frame_start_i) begin
      if (diff > RateW) begin
        cur_d = cur_q + RateS;
      end else if (diff < -RateW) begin
        cur_d = cur_q - RateS;
      end else begin
        cur_d = target_q;
      end
    end
  end

  // Game over needs the animation settled at an end stop; rounds are refused
  // on that detection cycle so the target cannot slip away from cur in OVER.
  always_comb begin
    reached  = (state_q == PLAY) && (cur_q == target_q) &&
               ((cur_q == MaxS) || (cur_q == -MaxS));
    state_d  = state_q;
    winner_d = winner_q;
    target_d = target_q;
    if (game_clear_i) begin
      target_d = '0;
      winner_d = 2'b00;
      state_d  = PLAY;
    end else if (reached) begin
      state_d  = OVER;
      winner_d = cur_q[9] ? 2'b01 : 2'b10;
    end else if ((state_q == PLAY) && round_pulse_i && !tie_i) begin
      if (right_i) begin
        target_d = (target_q >= MaxS - StepS) ? MaxS : target_q + StepS;
      end else begin
        target_d = (target_q <= StepS - MaxS) ? -MaxS : target_q - StepS;
      end
    end
    red_d  = RedHome + $unsigned(cur_d);
    blue_d = BlueHome + $unsigned(cur_d);
    busy_d = (cur_d != target_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= PLAY;
      target_q <= '0;
      cur_q    <= '0;
      red_q    <= RedHome;
      blue_q   <= BlueHome;
      winner_q <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      red_q    <= red_d;
      blue_q   <= blue_d;
      winner_q <= winner_d;
      busy_q   <= busy_d;
    end
  end

`ifdef WIN_FLASH_EN
  localparam int CntW = $clog2(FLASH_FRAMES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flash_q, flash_d;

  // Flash starts lit on OVER entry and toggles every FLASH_FRAMES frames.
  always_comb begin
    cnt_d   = cnt_q;
    flash_d = flash_q;
    if (game_clear_i) begin
      cnt_d   = '0;
      flash_d = 1'b0;
    end else if (reached) begin
      cnt_d   = '0;
      flash_d = 1'b1;
    end else if ((state_q == OVER) && frame_start_i) begin
      if (cnt_q == CntW'(FLASH_FRAMES - 1)) begin
        cnt_d   = '0;
        flash_d = ~flash_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      flash_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
    end
  end

  assign flash_o = flash_q;
`else
  assign flash_o = 1'b0;
`endif

  assign red_start_o  = red_q;
  assign blue_start_o = blue_q;
  assign winner_o     = winner_q;
  assign anim_busy_o  = busy_q;

endmodule

// File: doc/rope_anim_ctrl.md
Name: rope_anim_ctrl

Overview:
- Sequences the two player_draw sprites of the tug-of-war display by generating their horizontal start positions from round results.
- Holds a signed rope offset and a target offset; each won round moves the target toward the winner.
- The displayed offset walks toward the target only at frame boundaries, so sprites never tear mid-frame.
- Detects the game-over condition and reports the winner for the scorer/LED path.

Parameters:
- RED_HOME, 500, red (right) sprite start column at offset 0
- BLUE_HOME, 300, blue (left) sprite start column at offset 0
- STEP, 16, target offset change per won round (pixels)
- MAX_OFFSET, 96, absolute offset that ends the game (must be a multiple of STEP)
- ANIM_RATE, 2, maximum pixels the displayed offset moves per frame
- FLASH_FRAMES, 15, frames per flash half-period (optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- round_pulse  in  1  one-cycle pulse: a round result is valid
- right  in  1  valid with round_pulse: 1 = right/red won, 0 = left/blue won
- tie  in  1  valid with round_pulse: 1 = tie, which has no effect
- game_clear  in  1  one-cycle synchronous request to start a new game
- red_start  out  10  red sprite start column
- blue_start  out  10  blue sprite start column
- winner  out  2  00 none, 01 left/blue, 10 right/red
- anim_busy  out  1  displayed offset differs from target
- flash  out  1  winner flash enable

Behaviour:
- Reset (rst=0, asynchronous):
  - target=0, cur=0, state=PLAY.
  - red_start=RED_HOME, blue_start=BLUE_HOME.
  - winner=00, anim_busy=0, flash=0.
- Offsets:
  - target and cur are signed 10-bit; positive means toward the right.
  - red_start = RED_HOME+cur and blue_start = BLUE_HOME+cur, both registered.
- States: PLAY, OVER.
- PLAY, on round_pulse with tie=0:
  - right=1: target = min(target+STEP, +MAX_OFFSET).
  - right=0: target = max(target-STEP, -MAX_OFFSET).
  - round_pulse with tie=1 changes nothing.
- Frame update, on frame_start in any state:
  - If |target-cur| <= ANIM_RATE, then cur=target; otherwise cur moves ANIM_RATE toward target.
  - red_start/blue_start update on the same edge; they never change outside a frame_start cycle except at reset.
- Simultaneous round_pulse and frame_start:
  - The frame step uses the old target.
  - The new target takes effect from the next frame.
- anim_busy is a registered flag, equal to (cur != target) evaluated after the update edge.
- Game-over detection:
  - PLAY goes to OVER on the cycle after cur reaches +MAX_OFFSET (winner=10) or -MAX_OFFSET (winner=01).
  - Detection is on cur, not target, so winner asserts only after the animation completes.
- OVER:
  - round_pulse is ignored.
  - cur and target hold; winner holds.
- game_clear, in any state:
  - target=0, winner=00 next cycle, state=PLAY.
  - cur animates back toward 0 at ANIM_RATE per frame; anim_busy=1 until it arrives.
  - Round pulses accepted during this return animation retarget normally.
- game_clear coincident with round_pulse: game_clear wins and the round is discarded.
- Reset mid-animation: returns immediately to the reset values above.

Optional Feature:
- Macro: WIN_FLASH_EN.
- Defined:
  - In OVER, a frame counter counts frame_start pulses.
  - flash toggles every FLASH_FRAMES frames, starting at 1 on OVER entry.
  - flash is cleared with the counter on game_clear or reset.
- Not defined: flash is tied to 0, and no counter is generated.

Test Plan:
- Reset release, no activity -> red_start=500, blue_start=300, winner=00, anim_busy=0.
- One round_pulse right=1, then 8 frame_start pulses:
  - anim_busy=1 after the pulse.
  - red_start steps 502, 504 … 516 (blue_start 302 … 316), one step per frame.
  - anim_busy=0 after the 8th frame.
- round_pulse with tie=1, then frames -> positions unchanged, anim_busy stays 0.
- Six right=1 rounds back-to-back, then 48 frames:
  - red_start=596.
  - winner=10 on the cycle after the 48th frame.
  - A further round_pulse right=0 does not move the target.
- From OVER (winner=10), pulse game_clear:
  - winner=00 next cycle.
  - red_start decreases by 2 per frame back to 500, anim_busy clearing on arrival.
- round_pulse coincident with frame_start while cur=target=0 -> no move that frame; a 2-pixel move on the following frame.
- With WIN_FLASH_EN, FLASH_FRAMES=15 -> in OVER, flash toggles every 15 frame_start pulses; game_clear forces flash=0.
